// File: rtl/palette_pkg.sv
// Shared types and fade arithmetic for the sprite palette engine.
package palette_pkg;

  localparam int PAL_CH_W = 4;

  typedef struct packed {
    logic [PAL_CH_W-1:0] r;
    logic [PAL_CH_W-1:0] g;
    logic [PAL_CH_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pal_state_e;

  // Brightness: (c * (fade+1)) >> 4, truncating, so fade=15 is identity.
  function automatic logic [PAL_CH_W-1:0] fade_scale(input logic [PAL_CH_W-1:0] c,
                                                     input logic [3:0]          fade);
    logic [PAL_CH_W+3:0] p;
    p = (PAL_CH_W+4)'(c) * (PAL_CH_W+4)'({1'b0, fade} + 5'd1);
    return p[PAL_CH_W+3:4];
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port synchronous RAM, read-first on same-address collision.
module palette_ram #(
  parameter int AW    = 10,
  parameter int DW    = 12,
  parameter int DEPTH = 1 << AW
) (
  input  logic          gclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Both ports update on the same edge; the read sees pre-write contents.
  always_ff @(posedge gclk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sprite_palette_engine.sv
// Multi-palette colour lookup: self-clear on reset, user writes, 2-cycle
// lookup pipeline with transparency key and fade scaling.
module sprite_palette_engine
  import palette_pkg::*;
#(
  parameter int IDX_W     = 8,
  parameter int CH_W      = 4,
  parameter int NUM_PAL   = 4,
  parameter int TRANS_IDX = 0
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  output logic                       busy,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [3*CH_W-1:0]          wr_rgb,
  input  logic                       rd_valid,
  input  logic [$clog2(NUM_PAL)-1:0] rd_pal,
  input  logic [IDX_W-1:0]           rd_idx,
  input  logic                       trans_en,
  input  logic [3:0]                 fade,
  output logic                       px_valid,
  output logic [CH_W-1:0]            red,
  output logic [CH_W-1:0]            green,
  output logic [CH_W-1:0]            blue,
  output logic                       px_transparent
);

  localparam int PAL_W  = $clog2(NUM_PAL);
  localparam int AW     = PAL_W + IDX_W;
  localparam int DEPTH  = NUM_PAL << IDX_W;
  localparam int STAGES = 2;

  pal_state_e    state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q, wr_ready_q;

  // Clear sweep; the depth is a power of two so all-ones marks the last address.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      busy_q     <= 1'b1;
      wr_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + AW'(1);
          if (&ptr_q) begin
            state_q    <= ST_RUN;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          busy_q     <= 1'b0;
          wr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign wr_ready = wr_ready_q;

  logic              ram_we, rd_go;
  logic [AW-1:0]     ram_waddr;
  logic [3*CH_W-1:0] ram_wdata;
  rgb_t              ram_q;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = {wr_pal, wr_idx};
    ram_wdata = wr_rgb;
    if (Reset_n) begin
      if (state_q == ST_INIT) begin
        ram_we    = 1'b1;
        ram_waddr = ptr_q;
        ram_wdata = '0;
      end else begin
        ram_we = wr_valid & wr_ready_q;
      end
    end
  end

  // Lookups are only launched once the clear has finished.
  assign rd_go = Reset_n & rd_valid & (state_q == ST_RUN);

  palette_ram #(.AW(AW), .DW(3*CH_W), .DEPTH(DEPTH)) u_ram (
    .gclk  (Clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_go),
    .raddr ({rd_pal, rd_idx}),
    .rdata (ram_q)
  );

  logic [STAGES-1:0] vld_pipe;
  logic [3:0]        fade_s1;
  logic              trans_s1;
  rgb_t              rgb_q;
  logic              trans_q;

  // Stage 1 travels alongside the RAM read; stage 2 registers the scaled colour.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vld_pipe <= '0;
      fade_s1  <= '0;
      trans_s1 <= 1'b0;
      rgb_q    <= '0;
      trans_q  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], rd_go};
      fade_s1  <= fade;
      trans_s1 <= trans_en & (rd_idx == IDX_W'(TRANS_IDX));
      rgb_q.r  <= fade_scale(ram_q.r, fade_s1);
      rgb_q.g  <= fade_scale(ram_q.g, fade_s1);
      rgb_q.b  <= fade_scale(ram_q.b, fade_s1);
      trans_q  <= trans_s1;
    end
  end

  assign px_valid       = vld_pipe[STAGES-1];
  assign red            = rgb_q.r;
  assign green          = rgb_q.g;
  assign blue           = rgb_q.b;
  assign px_transparent = trans_q;

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Bench for sprite_palette_engine: directed vector table, corner sequences and
// randomized traffic against an array/queue reference model.
module tb_sprite_palette_engine;

  localparam int DEPTH = 1024;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        busy, wr_ready;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_pal = '0;
  logic [7:0]  wr_idx = '0;
  logic [11:0] wr_rgb = '0;
  logic        rd_valid = 1'b0;
  logic [1:0]  rd_pal = '0;
  logic [7:0]  rd_idx = '0;
  logic        trans_en = 1'b0;
  logic [3:0]  fade = 4'd15;
  logic        px_valid;
  logic [3:0]  red, green, blue;
  logic        px_transparent;

  always #5 Clk = ~Clk;

  sprite_palette_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .busy(busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pal(wr_pal), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
    .rd_valid(rd_valid), .rd_pal(rd_pal), .rd_idx(rd_idx), .trans_en(trans_en), .fade(fade),
    .px_valid(px_valid), .red(red), .green(green), .blue(blue), .px_transparent(px_transparent)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: palette contents, run flag, and expected results with due cycle.
  logic [11:0] ref_mem [DEPTH];
  typedef struct { int due; logic [11:0] rgb; logic tr; } exp_t;
  exp_t expq[$];
  bit   m_run = 1'b0;
  int   m_cnt = 0;

  function automatic logic [3:0] sc(input logic [3:0] c, input logic [3:0] f);
    int p;
    p = int'(c) * (int'(f) + 1);
    return 4'(p / 16);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    logic [11:0] v;
    if (!Reset_n) begin
      m_run = 1'b0;
      m_cnt = 0;
      expq.delete();
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else if (!m_run) begin
      m_cnt++;
      if (m_cnt == DEPTH) m_run = 1'b1;
    end else begin
      if (rd_valid) begin
        v     = ref_mem[{rd_pal, rd_idx}];
        e.due = cyc + 2;
        e.rgb = {sc(v[11:8], fade), sc(v[7:4], fade), sc(v[3:0], fade)};
        e.tr  = trans_en && (rd_idx == 8'd0);
        expq.push_back(e);
      end
      if (wr_valid) ref_mem[{wr_pal, wr_idx}] = wr_rgb;
    end
    @(posedge Clk);
    #1;
    cyc++;
    chk("busy", busy, !m_run);
    chk("wr_ready", wr_ready, m_run);
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      chk("px_valid", px_valid, 1);
      chk("rgb", {red, green, blue}, e.rgb);
      chk("px_transparent", px_transparent, e.tr);
    end else begin
      chk("px_valid_idle", px_valid, 0);
    end
  endtask

  task automatic wr(input logic [1:0] p, input logic [7:0] i, input logic [11:0] c);
    wr_valid = 1'b1; wr_pal = p; wr_idx = i; wr_rgb = c;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (busy && n < 1200) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic [1:0] pal; logic [7:0] idx; logic [3:0] fd; logic te;
    logic [11:0] rgb; logic tr;
  } vec_t;
  vec_t vt[9];

  initial begin
    int n;
    vt[0] = '{2'd3, 8'hFF, 4'd15, 1'b0, 12'h000, 1'b0};
    vt[1] = '{2'd1, 8'h2A, 4'd15, 1'b0, 12'hE72, 1'b0};
    vt[2] = '{2'd0, 8'h2A, 4'd15, 1'b0, 12'h000, 1'b0};
    vt[3] = '{2'd1, 8'h2A, 4'd7,  1'b0, 12'h731, 1'b0};
    vt[4] = '{2'd1, 8'h2A, 4'd0,  1'b0, 12'h000, 1'b0};
    vt[5] = '{2'd1, 8'h00, 4'd15, 1'b1, 12'h5AF, 1'b1};
    vt[6] = '{2'd1, 8'h00, 4'd15, 1'b0, 12'h5AF, 1'b0};
    vt[7] = '{2'd1, 8'h01, 4'd15, 1'b1, 12'h000, 1'b0};
    vt[8] = '{2'd1, 8'h2A, 4'd3,  1'b0, 12'h310, 1'b0};

    // Reset state
    Reset_n = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_px_valid", px_valid, 0);
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_px_transparent", px_transparent, 0);

    // Init sweep with lookups requested throughout (all must be dropped)
    Reset_n = 1'b1;
    rd_valid = 1'b1; rd_pal = 2'd3; rd_idx = 8'hFF;
    wait_init(n);
    chk("init_len", n, 1024);
    rd_valid = 1'b0;

    wr(2'd1, 8'h2A, 12'hE72);
    wr(2'd1, 8'h00, 12'h5AF);

    foreach (vt[i]) begin
      rd_valid = 1'b1; rd_pal = vt[i].pal; rd_idx = vt[i].idx;
      fade = vt[i].fd; trans_en = vt[i].te;
      tick();
      rd_valid = 1'b0;
      fade = ~fade; trans_en = ~trans_en;
      tick();
      chk("vec_valid", px_valid, 1);
      chk("vec_rgb", {red, green, blue}, vt[i].rgb);
      chk("vec_trans", px_transparent, vt[i].tr);
    end
    trans_en = 1'b0;

    // Streaming burst with fade changing every cycle
    for (int i = 0; i < 8; i++) begin
      rd_valid = 1'b1; rd_pal = 2'd1; rd_idx = 8'h2A; fade = 4'(i * 2 + 1);
      tick();
    end
    rd_valid = 1'b0;
    tick(); tick();

    // Read/write collision on the same address
    wr(2'd2, 8'd5, 12'h123);
    fade = 4'd15;
    rd_valid = 1'b1; rd_pal = 2'd2; rd_idx = 8'd5;
    wr_valid = 1'b1; wr_pal = 2'd2; wr_idx = 8'd5; wr_rgb = 12'hD83;
    tick();
    wr_valid = 1'b0;
    tick();
    rd_valid = 1'b0;
    chk("coll_old", {red, green, blue}, 12'h123);
    tick();
    chk("coll_new", {red, green, blue}, 12'hD83);

    // Randomized traffic, biased to a few addresses for collisions and keying
    for (int i = 0; i < 1500; i++) begin
      wr_valid = 1'($urandom);
      wr_pal   = 2'($urandom);
      wr_idx   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      wr_rgb   = 12'($urandom);
      rd_valid = ($urandom_range(0, 3) != 0);
      rd_pal   = 2'($urandom);
      rd_idx   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      fade     = 4'($urandom);
      trans_en = 1'($urandom);
      tick();
    end
    wr_valid = 1'b0; rd_valid = 1'b0; trans_en = 1'b0;
    tick(); tick();

    // Reset in the middle of a 10-deep read burst
    wr(2'd1, 8'h2A, 12'hE72);
    fade = 4'd15;
    for (int i = 0; i < 10; i++) begin
      rd_valid = 1'b1; rd_pal = 2'd1; rd_idx = 8'h2A;
      Reset_n = (i != 5);
      tick();
      if (i == 5) begin
        chk("midrst_px_valid", px_valid, 0);
        chk("midrst_busy", busy, 1);
      end
    end
    Reset_n = 1'b1;
    rd_valid = 1'b0;
    wait_init(n);
    chk("reinit_done", busy, 0);
    rd_valid = 1'b1; rd_pal = 2'd1; rd_idx = 8'h2A;
    tick();
    rd_valid = 1'b0;
    tick();
    chk("reinit_valid", px_valid, 1);
    chk("reinit_cleared", {red, green, blue}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_palette_engine.md
# sprite_palette_engine

Runtime-writable, multi-palette colour lookup for sprite rendering; successor to the fixed per-sprite ROM palettes. Holds `NUM_PAL` palettes of `2**IDX_W` entries of 12-bit RGB in one synchronous RAM. It clears itself after reset, accepts palette writes from the game controller, and serves a pixel-rate lookup stream with a 2-cycle latency. The output adds transparency-key detection and a global fade (brightness) scale. Sits between the sprite ROM address stage and the VGA colour mux.

## Interface
- `IDX_W`, default 8: colour index width.
- `CH_W`, default 4: bits per colour channel.
- `NUM_PAL`, default 4: number of palettes (power of two).
- `TRANS_IDX`, default 0: index value treated as transparent.
- `Clk`, in, 1: single clock.
- `Reset_n`, in, 1: reset is synchronous and active-low (sampled on `Clk` rising edge; 0 = reset).
- `busy`, out, 1: high while the init clear runs.
- `wr_valid`, in, 1: write request.
- `wr_ready`, out, 1: write accepted when `wr_valid & wr_ready`.
- `wr_pal`, in, log2(NUM_PAL): palette to write.
- `wr_idx`, in, IDX_W: entry to write.
- `wr_rgb`, in, 3*CH_W: colour {R,G,B}.
- `rd_valid`, in, 1: lookup request; no backpressure.
- `rd_pal`, in, log2(NUM_PAL): palette select.
- `rd_idx`, in, IDX_W: colour index.
- `trans_en`, in, 1: enable transparency keying.
- `fade`, in, 4: brightness; 15 = full, 0 = 1/16.
- `px_valid`, out, 1: result valid.
- `red`, `green`, `blue`, out, CH_W each: scaled colour.
- `px_transparent`, out, 1: pixel is keyed out.

## Operation
- FSM states: INIT, RUN.
- Reset places the FSM in INIT with the clear pointer at 0. Reset values: `busy`=1, `wr_ready`=0, `px_valid`=0, `red`/`green`/`blue`=0, `px_transparent`=0.
- INIT behaviour:
  - Writes 0 to address `ptr` each cycle; `ptr` spans 0..NUM_PAL*2**IDX_W-1 (1024 cycles at defaults).
  - Moves to RUN the cycle after the last address is written.
  - `rd_valid` is ignored and `wr_ready`=0.
- RUN behaviour:
  - `busy`=0, `wr_ready`=1. Each handshake writes `wr_rgb` to address {wr_pal, wr_idx}.
  - Each `rd_valid` cycle launches one lookup at {rd_pal, rd_idx}. Back-to-back lookups run every cycle.
- Fade arithmetic, per channel: out = (c * (fade+1)) >> 4. The product is CH_W+4 bits; take the upper CH_W bits; no rounding. With fade=15 the output equals c exactly.
- Transparency: `px_transparent` = `trans_en` & (rd_idx == TRANS_IDX). On a transparent pixel RGB still carries the scaled palette value.
- Read/write collision on the same address in the same cycle: the read returns the old data (read-first). The write completes.
- `Reset_n` low mid-operation, in any state:
  - The next edge aborts in-flight lookups, drops `px_valid` to 0 and restarts INIT from `ptr`=0.
  - Palette contents are re-cleared.

## Timing
- Lookup latency is 2 cycles.
  - Cycle N: `rd_valid`/`rd_idx`/`rd_pal` sampled, RAM read issued. `fade`, `trans_en` and the index-compare result are captured into stage 1.
  - Cycle N+1: RAM data available; scale computed and registered.
  - Cycle N+2: `px_valid`=1 with `red`/`green`/`blue`/`px_transparent` valid.
- `fade` and `trans_en` are sampled with the lookup they apply to. Changing them mid-stream affects only later lookups.
- Pipeline valid bits clear to 0 on reset. A lookup presented on the last INIT cycle is dropped.
- A write is visible to a lookup issued 1 or more cycles after the write cycle.
- `busy` falls on the same edge on which `wr_ready` rises.

## Structure
- Shared package `palette_pkg`:
  - `rgb_t` packed struct {r,g,b} of CH_W each.
  - FSM state enum `pal_state_e`.
  - Function `fade_scale(c, fade)`.
- One sub-module `palette_ram`:
  - Simple dual-port synchronous RAM: one write port, one read port, read-first, depth NUM_PAL*2**IDX_W, width 3*CH_W.
  - No reset on the storage array.
- Top module holds the FSM, clear counter, write mux (clear vs. user), 2-stage lookup pipeline and scaling.

## Test plan
- **Reset/init:** release `Reset_n` → `busy`=1 for exactly 1024 cycles, `wr_ready`=0 throughout. Then read pal 3, idx 255 → RGB 0,0,0 at N+2.
- **Write/read:** write pal 1, idx 0x2A = {E,7,2} → read with fade=15 returns E,7,2 two cycles later. The same idx in pal 0 returns 0,0,0.
- **Fade:** the entry above read with fade=7 → 7,3,1. With fade=0 → 0,0,0. Toggling `fade` every cycle in a streaming burst shows each result scaled by its own sampled fade.
- **Transparency:** `trans_en`=1, idx 0 → `px_transparent`=1. `trans_en`=0, idx 0 → 0. `trans_en`=1, idx 1 → 0.
- **Collision:** write {D,8,3} to pal 2 idx 5 while reading the same address in the same cycle → old value returned. A read on the next cycle returns D,8,3.
- **Mid-reset:** assert `Reset_n`=0 for 1 cycle during a 10-deep read burst → `px_valid` is 0 from the next edge. `busy` reasserts. The earlier-written entry reads back 0 after init.
